// File: rtl/bcd_disp_pkg.sv
// Shared constants for the two-digit BCD display scanner: segment patterns,
// slot encoding and the captured display word.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_0    = 7'h3F;
    localparam logic [6:0] SEG_1    = 7'h06;
    localparam logic [6:0] SEG_2    = 7'h5B;
    localparam logic [6:0] SEG_3    = 7'h4F;
    localparam logic [6:0] SEG_4    = 7'h66;
    localparam logic [6:0] SEG_5    = 7'h6D;
    localparam logic [6:0] SEG_6    = 7'h7D;
    localparam logic [6:0] SEG_7    = 7'h07;
    localparam logic [6:0] SEG_8    = 7'h7F;
    localparam logic [6:0] SEG_9    = 7'h6F;
    localparam logic [6:0] SEG_DASH = 7'h40;

    typedef enum logic {
        SLOT_ONES = 1'b0,
        SLOT_TENS = 1'b1
    } slot_e;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] ones;
        logic       blank_lz;
        logic       blink;
    } disp_word_t;

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD to 7-segment decoder, active-high segments (bit0 = a).
// Non-BCD codes show a dash so a bad digit is visible rather than garbage.
module seven_seg_decode
    import bcd_disp_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        case (value)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Two-digit multiplexed 7-segment driver: captures tens/ones on load_i, commits
// them only at slot boundaries, scans anodes with dead time, blanking and blink.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLINK_SLOTS    = 256,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [3:0] tens_i,
    input  logic [3:0] ones_i,
    input  logic       blank_lz_i,
    input  logic       blink_i,
    output logic [6:0] seg_o,
    output logic [1:0] an_o,
    output logic       pending_o,
    output logic       err_o
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_SLOTS > 1) ? $clog2(BLINK_SLOTS) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLK_LAST = BW'(BLINK_SLOTS - 1);
    localparam logic [6:0]    SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]    AN_OFF   = AN_ACTIVE_LOW  ? 2'b11 : 2'b00;

    logic [CW-1:0] cnt_q, cnt_n;
    slot_e         slot_q, slot_n;
    logic [BW-1:0] blk_cnt_q, blk_cnt_n;
    logic          phase_q, phase_n;
    disp_word_t    pend_q, pend_n;
    disp_word_t    disp_q, disp_n;
    logic          pending_n;
    logic          boundary;
    logic [3:0]    digit_n;
    logic [6:0]    seg_raw;
    logic [1:0]    an_raw;
    logic          err_n;

    assign boundary = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_n     = boundary ? '0 : cnt_q + CW'(1);
        slot_n    = boundary ? slot_e'(~slot_q) : slot_q;
        blk_cnt_n = blk_cnt_q;
        phase_n   = phase_q;
        if (boundary) begin
            if (blk_cnt_q == BLK_LAST) begin
                blk_cnt_n = '0;
                phase_n   = ~phase_q;
            end else begin
                blk_cnt_n = blk_cnt_q + BW'(1);
            end
        end

        // Old pending value commits before a same-cycle load replaces it.
        disp_n    = (boundary && pending_o) ? pend_q : disp_q;
        pending_n = (boundary && pending_o) ? 1'b0 : pending_o;
        pend_n    = pend_q;
        if (load_i) begin
            pend_n    = '{tens: tens_i, ones: ones_i, blank_lz: blank_lz_i, blink: blink_i};
            pending_n = 1'b1;
        end
    end

    // Outputs are computed from next-state values so they line up with cnt.
    assign digit_n = (slot_n == SLOT_TENS) ? disp_n.tens : disp_n.ones;

    seven_seg_decode u_decode (
        .value (digit_n),
        .seg   (seg_raw)
    );

    always_comb begin
        an_raw = 2'b00;
        if (cnt_n == '0) begin
            an_raw = 2'b00;
        end else if (disp_n.blink && phase_n) begin
            an_raw = 2'b00;
        end else if (slot_n == SLOT_TENS) begin
            an_raw = (disp_n.blank_lz && disp_n.tens == 4'd0) ? 2'b00 : 2'b10;
        end else begin
            an_raw = 2'b01;
        end
        err_n = (disp_n.tens > 4'd9) || (disp_n.ones > 4'd9);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            slot_q    <= SLOT_ONES;
            blk_cnt_q <= '0;
            phase_q   <= 1'b0;
            pend_q    <= '0;
            disp_q    <= '0;
            pending_o <= 1'b0;
            seg_o     <= SEG_OFF;
            an_o      <= AN_OFF;
            err_o     <= 1'b0;
        end else begin
            cnt_q     <= cnt_n;
            slot_q    <= slot_n;
            blk_cnt_q <= blk_cnt_n;
            phase_q   <= phase_n;
            pend_q    <= pend_n;
            disp_q    <= disp_n;
            pending_o <= pending_n;
            seg_o     <= SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
            an_o      <= AN_ACTIVE_LOW ? ~an_raw : an_raw;
            err_o     <= err_n;
        end
    end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner (REFRESH_DIV=4, BLINK_SLOTS=2, active-low outputs):
// directed steps plus random loads against a cycle-indexed reference model.
module tb_bcd_display_scanner;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_i = 1'b0;
    logic [3:0] tens_i = 4'd0;
    logic [3:0] ones_i = 4'd0;
    logic       blank_lz_i = 1'b0;
    logic       blink_i = 1'b0;
    logic [6:0] seg_o;
    logic [1:0] an_o;
    logic       pending_o;
    logic       err_o;

    bcd_display_scanner #(
        .REFRESH_DIV    (4),
        .BLINK_SLOTS    (2),
        .SEG_ACTIVE_LOW (1'b1),
        .AN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load_i),
        .tens_i     (tens_i),
        .ones_i     (ones_i),
        .blank_lz_i (blank_lz_i),
        .blink_i    (blink_i),
        .seg_o      (seg_o),
        .an_o       (an_o),
        .pending_o  (pending_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // Model: k = edges since reset release; slot and blink phase follow from k.
    logic [6:0] seg_tab [16];
    int   k = 0;
    bit   m_rst = 1'b1;
    logic [3:0] p_t = 0, p_o = 0, d_t = 0, d_o = 0;
    bit   p_b = 0, p_k = 0, p_v = 0, d_b = 0, d_k = 0;

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h (k=%0d)", tag, obs, exp, k);
        end
    endtask

    task automatic check_all();
        logic [6:0] e_seg;
        logic [1:0] e_act;
        logic       e_err, e_pend;
        int         cnt, slot, ph;
        if (m_rst) begin
            e_seg = 7'h7F; e_act = 2'b00; e_err = 1'b0; e_pend = 1'b0;
        end else begin
            cnt  = k % 4;
            slot = (k / 4) % 2;
            ph   = (k / 8) % 2;
            e_seg = ~seg_tab[(slot == 1) ? d_t : d_o];
            if (cnt == 0)                         e_act = 2'b00;
            else if (d_k && ph == 1)              e_act = 2'b00;
            else if (slot == 1 && d_b && d_t == 0) e_act = 2'b00;
            else                                  e_act = (slot == 1) ? 2'b10 : 2'b01;
            e_err  = (d_t > 9) || (d_o > 9);
            e_pend = p_v;
        end
        chk("seg", seg_o, e_seg);
        chk("an", {5'b0, an_o}, {5'b0, ~e_act});
        chk("pending", {6'b0, pending_o}, {6'b0, e_pend});
        chk("err", {6'b0, err_o}, {6'b0, e_err});
    endtask

    task automatic cyc();
        @(posedge clk);
        if ((k % 4) == 3 && p_v) begin
            d_t = p_t; d_o = p_o; d_b = p_b; d_k = p_k; p_v = 0;
        end
        if (load_i) begin
            p_t = tens_i; p_o = ones_i; p_b = blank_lz_i; p_k = blink_i; p_v = 1;
        end
        k++;
        #1;
        check_all();
        load_i = 1'b0;
    endtask

    task automatic ld(input logic [3:0] t, input logic [3:0] o, input bit b, input bit bl);
        tens_i = t; ones_i = o; blank_lz_i = b; blink_i = bl; load_i = 1'b1;
        cyc();
    endtask

    task automatic run(input int n);
        repeat (n) cyc();
    endtask

    task automatic go_cnt(input int c);
        while ((k % 4) != c) cyc();
    endtask

    task automatic go_pos8(input int c);
        while ((k % 8) != c) cyc();
    endtask

    task automatic model_reset();
        m_rst = 1; k = 0;
        p_t = 0; p_o = 0; p_b = 0; p_k = 0; p_v = 0;
        d_t = 0; d_o = 0; d_b = 0; d_k = 0;
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

        // Reset and first slot
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        m_rst = 0;
        cyc();
        chk("rst_an_slot0", {5'b0, an_o}, 7'h02);
        chk("rst_seg_zero", seg_o, 7'h40);
        run(1);

        // Load 1/5 mid-slot
        ld(4'd1, 4'd5, 1'b0, 1'b0);
        chk("pend_set", {6'b0, pending_o}, 7'h01);
        cyc();
        chk("pend_clr", {6'b0, pending_o}, 7'h00);
        chk("dead_time", {5'b0, an_o}, 7'h03);
        chk("tens_seg1", seg_o, 7'h79);
        cyc();
        chk("tens_an", {5'b0, an_o}, 7'h01);
        go_pos8(1);
        chk("ones_an", {5'b0, an_o}, 7'h02);
        chk("ones_seg5", seg_o, 7'h12);

        // Leading-zero blanking
        ld(4'd0, 4'd7, 1'b1, 1'b0);
        run(8);
        go_pos8(5);
        chk("lz_blank_an", {5'b0, an_o}, 7'h03);
        go_pos8(1);
        chk("lz_ones_seg7", seg_o, 7'h78);
        ld(4'd0, 4'd7, 1'b0, 1'b0);
        run(8);
        go_pos8(5);
        chk("lz_off_an", {5'b0, an_o}, 7'h01);
        chk("lz_off_seg0", seg_o, 7'h40);

        // Invalid digit
        ld(4'd2, 4'd12, 1'b0, 1'b0);
        run(8);
        go_pos8(1);
        chk("bad_dash", seg_o, 7'h3F);
        chk("bad_err", {6'b0, err_o}, 7'h01);
        ld(4'd2, 4'd3, 1'b0, 1'b0);
        run(4);
        chk("err_clr", {6'b0, err_o}, 7'h00);

        // Blink on, then off
        ld(4'd3, 4'd4, 1'b0, 1'b1);
        run(32);
        ld(4'd3, 4'd4, 1'b0, 1'b0);
        run(16);

        // Load landing exactly on the boundary cycle
        go_cnt(1);
        ld(4'd6, 4'd6, 1'b0, 1'b0);
        go_cnt(3);
        ld(4'd8, 4'd8, 1'b0, 1'b0);
        chk("race_pend", {6'b0, pending_o}, 7'h01);
        run(4);
        chk("race_pend_clr", {6'b0, pending_o}, 7'h00);

        // Random loads
        repeat (300) begin
            if ($urandom_range(5) == 0)
                ld(4'($urandom_range(15)), 4'($urandom_range(15)),
                   1'($urandom_range(1)), 1'($urandom_range(1)));
            else
                cyc();
        end

        // Reset mid-slot with a pending load
        go_cnt(1);
        ld(4'd9, 4'd9, 1'b0, 1'b0);
        #1;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("rst_mid_pend", {6'b0, pending_o}, 7'h00);
        chk("rst_mid_seg", seg_o, 7'h7F);
        @(negedge clk);
        rst_n = 1'b1;
        m_rst = 0;
        run(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
